// File: rtl/data_ram_resp.sv
// rtl/data_ram_resp.sv - word-organised data RAM responder with wait states; optional range check via DATA_RAM_RANGE_CHECK_EN
module data_ram_resp #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  sel,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        stallreq,
   output logic        ack,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int         DEPTH  = 1 << ADDR_W;
   localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   widx_q, widx_d;
   logic [3:0]          sel_q, sel_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [31:0]         data_o_q, data_o_d;
   logic                oor_q, oor_d;

   logic [31:0]         ram_q [DEPTH];
   logic [31:0]         ram_rd;
   logic [31:0]         lane_mask;
   logic                req_oor;
   logic                access_fire;
   logic                ram_we;

   // Byte-lane bits [1:0] never select a word; upper bits matter only for the range check.
   logic                unused_addr_bits;
   assign unused_addr_bits = ^{addr[1:0], addr[31:ADDR_W+2]};

`ifdef DATA_RAM_RANGE_CHECK_EN
   assign req_oor = |addr[31:ADDR_W+2];
`else
   assign req_oor = 1'b0;
`endif

   // Expand the captured lane enables into a 32-bit mask (sel[3] is the MSB byte).
   always_comb begin
      lane_mask = '0;
      for (int i = 0; i < 4; i++) begin
         lane_mask[i*8 +: 8] = {8{sel_q[i]}};
      end
   end

   assign ram_rd = ram_q[widx_q];

   // The access edge: last BUSY cycle with ce still high; a reset on that edge cancels it.
   assign access_fire = (state_q == BUSY) && ce && (cnt_q == WAIT_C) && !rst;
   assign ram_we      = access_fire && we_q && !oor_q;

   // Next-state, request capture and read-data update.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      widx_d   = widx_q;
      sel_d    = sel_q;
      wdata_d  = wdata_q;
      data_o_d = data_o_q;
      oor_d    = oor_q;
      case (state_q)
         IDLE: begin
            if (ce) begin
               we_d    = we;
               widx_d  = addr[ADDR_W+1:2];
               sel_d   = sel;
               wdata_d = data_i;
               oor_d   = req_oor;
               cnt_d   = 4'd0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (!ce) begin
               state_d = IDLE;
            end else if (cnt_q == WAIT_C) begin
               state_d = DONE;
               if (!we_q) begin
                  data_o_d = oor_q ? 32'h0 : (ram_rd & lane_mask);
               end
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and request registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         we_q     <= 1'b0;
         widx_q   <= '0;
         sel_q    <= 4'd0;
         wdata_q  <= 32'h0;
         data_o_q <= 32'h0;
         oor_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         we_q     <= we_d;
         widx_q   <= widx_d;
         sel_q    <= sel_d;
         wdata_q  <= wdata_d;
         data_o_q <= data_o_d;
         oor_q    <= oor_d;
      end
   end

   // RAM byte-lane writes; contents survive reset.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (sel_q[i]) begin
               ram_q[widx_q][i*8 +: 8] <= wdata_q[i*8 +: 8];
            end
         end
      end
   end

   assign data_o   = data_o_q;
   assign stallreq = ((state_q == IDLE) && ce) || (state_q == BUSY);
   assign ack      = (state_q == DONE);
   assign err      = (state_q == DONE) && oor_q;

endmodule

// File: tb/tb_data_ram_resp.sv
// tb/tb_data_ram_resp.sv - vector table plus scoreboard bench for data_ram_resp
module tb_data_ram_resp;

   localparam int W = 1;
`ifdef DATA_RAM_RANGE_CHECK_EN
   localparam logic RC = 1'b1;
`else
   localparam logic RC = 1'b0;
`endif

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        ce, we;
   logic [31:0] addr, data_i, data_o;
   logic [3:0]  sel;
   logic        stallreq, ack, err;

   logic        z_ce, z_we;
   logic [31:0] z_addr, z_data_i, z_data_o;
   logic [3:0]  z_sel;
   logic        z_stallreq, z_ack, z_err;

   data_ram_resp #(.ADDR_W(10), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
      .data_i(data_i), .data_o(data_o), .stallreq(stallreq), .ack(ack), .err(err)
   );

   data_ram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .ce(z_ce), .we(z_we), .addr(z_addr), .sel(z_sel),
      .data_i(z_data_i), .data_o(z_data_o), .stallreq(z_stallreq), .ack(z_ack), .err(z_err)
   );

   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];
   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int   cyc;
      int   stall;
      bit   done;
      exp_t e;
      @(negedge clk);
      ce = 1'b1; we = v.we; addr = v.addr; sel = v.sel; data_i = v.wdata;
      sb_q.push_back('{v.exp_data, v.exp_err});
      stall = 0; done = 0; cyc = 0;
      while (!done && cyc < 20) begin
         #1;
         if (ack) begin
            done = 1;
            if (sb_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL %s_unexpected_ack actual=1 required=0", tag);
            end else begin
               e = sb_q.pop_front();
               chk({tag, "_data"}, data_o, e.data);
               chk({tag, "_err"}, {31'h0, err}, {31'h0, e.err});
            end
            chk({tag, "_stall_in_ack"}, {31'h0, stallreq}, 32'h0);
            ce = 1'b0;
         end else begin
            if (stallreq) stall++;
            if (cyc == 1) begin
               we = ~v.we; addr = ~v.addr; sel = ~v.sel; data_i = ~v.wdata;
            end
         end
         cyc++;
         @(negedge clk);
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL %s_ack_timeout actual=none required=ack", tag);
         ce = 1'b0;
         if (sb_q.size() > 0) void'(sb_q.pop_front());
      end
      chk({tag, "_stall_cycles"}, stall, 2 + W);
      #1;
      chk({tag, "_ack_pulse"}, {31'h0, ack}, 32'h0);
      chk({tag, "_idle_stall"}, {31'h0, stallreq}, 32'h0);
   endtask

   task automatic z_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      z_ce = 1'b1; z_we = 1'b1; z_addr = a; z_sel = 4'hF; z_data_i = d;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("w0_write_ack", {31'h0, z_ack}, 32'h1);
      z_ce = 1'b0;
   endtask

   logic exp_stall_b2b [6];
   logic exp_ack_b2b   [6];
   exp_t e0;

   initial begin
      vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h0000_0011, 4'h4, 32'h5555_5555, 32'hDEAD_BEEF, 1'b0};
      vecs[3]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDE55_BEEF, 1'b0};
      vecs[4]  = '{1'b0, 32'h0000_0010, 4'h4, 32'h0,         32'h0055_0000, 1'b0};
      vecs[5]  = '{1'b1, 32'h0000_0010, 4'h3, 32'h1234_1234, 32'h0055_0000, 1'b0};
      vecs[6]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDE55_1234, 1'b0};
      vecs[7]  = '{1'b1, 32'h0000_0010, 4'h0, 32'hFFFF_FFFF, 32'hDE55_1234, 1'b0};
      vecs[8]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         32'hDE55_1234, 1'b0};
      vecs[9]  = '{1'b1, 32'h0000_0020, 4'hF, 32'hA5A5_0F0F, 32'hDE55_1234, 1'b0};
      vecs[10] = '{1'b0, 32'h0000_0022, 4'h8, 32'h0,         32'hA500_0000, 1'b0};
      vecs[11] = '{1'b0, 32'h0000_0020, 4'h1, 32'h0,         32'h0000_000F, 1'b0};
      vecs[12] = '{1'b1, 32'h0000_1010, 4'hF, 32'hCAFE_F00D, 32'h0000_000F, RC};
      vecs[13] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,
                   RC ? 32'hDE55_1234 : 32'hCAFE_F00D, 1'b0};
      vecs[14] = '{1'b0, 32'h0000_1010, 4'hF, 32'h0,
                   RC ? 32'h0000_0000 : 32'hCAFE_F00D, RC};

      exp_stall_b2b = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      exp_ack_b2b   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

      rst = 1'b1;
      ce = 1'b0; we = 1'b0; addr = '0; sel = '0; data_i = '0;
      z_ce = 1'b0; z_we = 1'b0; z_addr = '0; z_sel = '0; z_data_i = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_data_o", data_o, 32'h0);
      chk("rst_ack", {31'h0, ack}, 32'h0);
      chk("rst_stall", {31'h0, stallreq}, 32'h0);
      chk("rst_err", {31'h0, err}, 32'h0);
      chk("rst_w0_data_o", z_data_o, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i));
      end

      // Drop ce in the second BUSY cycle (the would-be access cycle) of a write.
      @(negedge clk);
      ce = 1'b1; we = 1'b1; addr = 32'h10; sel = 4'hF; data_i = 32'h0BAD_F00D;
      @(negedge clk);
      @(negedge clk);
      ce = 1'b0;
      #1;
      chk("abort_busy_stall", {31'h0, stallreq}, 32'h1);
      @(negedge clk);
      #1;
      chk("abort_no_ack", {31'h0, ack}, 32'h0);
      chk("abort_idle_stall", {31'h0, stallreq}, 32'h0);
      chk("abort_data_hold", data_o, vecs[14].exp_data);
      @(negedge clk);
      #1;
      chk("abort_no_late_ack", {31'h0, ack}, 32'h0);
      run_vec('{1'b0, 32'h10, 4'hF, 32'h0, RC ? 32'hDE55_1234 : 32'hCAFE_F00D, 1'b0}, "abort_rd");

      // Reset on the access edge of a write: no write, outputs back to reset values.
      @(negedge clk);
      ce = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'hF; data_i = 32'h1111_1111;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1; ce = 1'b0;
      @(negedge clk);
      #1;
      chk("midrst_data_o", data_o, 32'h0);
      chk("midrst_ack", {31'h0, ack}, 32'h0);
      chk("midrst_stall", {31'h0, stallreq}, 32'h0);
      chk("midrst_err", {31'h0, err}, 32'h0);
      rst = 1'b0;
      run_vec('{1'b0, 32'h20, 4'hF, 32'h0, 32'hA5A5_0F0F, 1'b0}, "midrst_rd");

      // Zero-wait instance: back-to-back reads with ce held high.
      z_write(32'h40, 32'h0102_0304);
      z_write(32'h44, 32'h0A0B_0C0D);
      @(negedge clk);
      z_ce = 1'b1; z_we = 1'b0; z_addr = 32'h40; z_sel = 4'hF;
      sb_q.push_back('{32'h0102_0304, 1'b0});
      sb_q.push_back('{32'h0A0B_0C0D, 1'b0});
      for (int c = 0; c < 6; c++) begin
         #1;
         chk($sformatf("b2b_stall_c%0d", c), {31'h0, z_stallreq}, {31'h0, exp_stall_b2b[c]});
         chk($sformatf("b2b_ack_c%0d", c), {31'h0, z_ack}, {31'h0, exp_ack_b2b[c]});
         if (z_ack) begin
            if (sb_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL b2b_unexpected_ack actual=1 required=0");
            end else begin
               e0 = sb_q.pop_front();
               chk($sformatf("b2b_data_c%0d", c), z_data_o, e0.data);
               chk($sformatf("b2b_err_c%0d", c), {31'h0, z_err}, {31'h0, e0.err});
            end
         end
         if (c == 1) z_addr = 32'h44;
         if (c == 5) z_ce = 1'b0;
         @(negedge clk);
      end
      if (sb_q.size() != 0) begin
         checks++; failures++;
         $display("FAIL b2b_missing_acks actual=%0d required=0", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
